// File: rtl/uart_rx_if.sv
// Receiver output bundle: single-entry byte register with valid/ready handshake
// plus the one-cycle error pulses.
interface uart_rx_if;
    logic       valid;
    logic       ready;
    logic [7:0] data;
    logic       frame_err;
    logic       overrun;

    modport master (output valid, data, frame_err, overrun, input ready);
    modport slave  (input valid, data, frame_err, overrun, output ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling with a down-counter
// timer, single-entry valid/ready output register with overrun/framing pulses.
//
//   state | meaning
//   IDLE  | line idle, waiting for rx_s low
//   START | counting half a bit to validate the start bit
//   DATA  | sampling 8 data bits, LSB first, one per bit period
//   STOP  | counting to the stop-bit sample, then deliver or flag
//   BREAK | stop bit was low; wait for the line to return high
module uart_rx (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] clkdiv,
    input  logic        rx,
    uart_rx_if.master   bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t      state, state_nxt;
    logic        rx_m, rx_s;
    logic [31:0] half;
    logic [31:0] clkcnt, clkcnt_nxt;
    logic [3:0]  bitcnt, bitcnt_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic [7:0]  data_q, data_nxt;
    logic        valid_q, valid_nxt;
    logic        ferr_q, ferr_nxt;
    logic        ovr_q, ovr_nxt;
    logic        tc;

    assign half = clkdiv >> 1;
    assign tc   = (clkcnt == 32'd0);

    assign bus.valid     = valid_q;
    assign bus.data      = data_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            state   <= IDLE;
            clkcnt  <= 32'd0;
            bitcnt  <= 4'd0;
            shreg   <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            rx_m    <= rx;
            rx_s    <= rx_m;
            state   <= state_nxt;
            clkcnt  <= clkcnt_nxt;
            bitcnt  <= bitcnt_nxt;
            shreg   <= shreg_nxt;
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
            ferr_q  <= ferr_nxt;
            ovr_q   <= ovr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        clkcnt_nxt = clkcnt;
        bitcnt_nxt = bitcnt;
        shreg_nxt  = shreg;
        data_nxt   = data_q;
        valid_nxt  = valid_q && !bus.ready;
        ferr_nxt   = 1'b0;
        ovr_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    clkcnt_nxt = half;
                    state_nxt  = START;
                end
            end
            START: begin
                if (!tc) begin
                    clkcnt_nxt = clkcnt - 32'd1;
                end else if (!rx_s) begin
                    clkcnt_nxt = clkdiv;
                    bitcnt_nxt = 4'd0;
                    state_nxt  = DATA;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DATA: begin
                if (!tc) begin
                    clkcnt_nxt = clkcnt - 32'd1;
                end else begin
                    shreg_nxt  = {rx_s, shreg[7:1]};
                    clkcnt_nxt = clkdiv;
                    bitcnt_nxt = bitcnt + 4'd1;
                    if (bitcnt == 4'd7)
                        state_nxt = STOP;
                end
            end
            STOP: begin
                if (!tc) begin
                    clkcnt_nxt = clkcnt - 32'd1;
                end else if (rx_s) begin
                    // A consume in this same cycle frees the register for the new byte.
                    if (!valid_q || bus.ready) begin
                        data_nxt  = shreg;
                        valid_nxt = 1'b1;
                    end else begin
                        ovr_nxt = 1'b1;
                    end
                    state_nxt = IDLE;
                end else begin
                    ferr_nxt  = 1'b1;
                    state_nxt = BREAK;
                end
            end
            BREAK: begin
                if (rx_s)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed timing/error scenarios plus randomized streams
// scored against an expected-byte queue.
module tb_uart_rx;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] clkdiv;
    logic        rx;

    uart_rx_if bus();

    uart_rx dut (
        .clk    (clk),
        .rst    (rst),
        .clkdiv (clkdiv),
        .rx     (rx),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int got_cnt = 0;
    int val_cycles = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: every accepted byte must be the oldest expected one.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.valid)     val_cycles++;
            if (bus.frame_err) fe_cnt++;
            if (bus.overrun)   ov_cnt++;
            if (bus.valid && bus.ready) begin
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0)
                    check("sb_data", {24'd0, bus.data}, {24'd0, exp_q.pop_front()});
                got_cnt++;
            end
        end
    end

    // Frame driver: call just after a rising edge; each bit lasts t cycles.
    task automatic send(input logic [7:0] b, input int t, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (t) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe0, ov0, got0, val0, t, h, nb, stall;
        logic [31:0] divs [4];
        logic done;
        divs[0] = 32'd1; divs[1] = 32'd2; divs[2] = 32'd7; divs[3] = 32'd434;

        rst = 1'b1; rx = 1'b1; bus.ready = 1'b0; clkdiv = 32'd3;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, bus.valid}, 32'd0);
        check("rst_data", {24'd0, bus.data}, 32'd0);
        check("rst_ferr", {31'd0, bus.frame_err}, 32'd0);
        check("rst_ovr", {31'd0, bus.overrun}, 32'd0);
        rst = 1'b0;
        tick(4);

        // Latency: T=4, H=1 -> valid rises 3+H+9T = 40 edges after edge k.
        bus.ready = 1'b1;
        fe0 = fe_cnt; ov0 = ov_cnt;
        exp_q.push_back(8'hA5);
        fork
            send(8'hA5, 4, 1'b1);
            begin
                @(posedge clk);
                repeat (39) @(posedge clk);
                #1;
                check("lat_before", {31'd0, bus.valid}, 32'd0);
                @(posedge clk);
                #1;
                check("lat_valid", {31'd0, bus.valid}, 32'd1);
                check("lat_data", {24'd0, bus.data}, 32'hA5);
            end
        join
        tick(4);
        check("lat_ferr", fe_cnt - fe0, 0);
        check("lat_ovr", ov_cnt - ov0, 0);

        // Start glitch shorter than half a bit is ignored.
        clkdiv = 32'd15;
        fe0 = fe_cnt; val0 = val_cycles; got0 = got_cnt;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(40);
        check("glitch_ferr", fe_cnt - fe0, 0);
        check("glitch_valid", val_cycles - val0, 0);
        exp_q.push_back(8'h3C);
        send(8'h3C, 16, 1'b1);
        tick(8);
        check("glitch_next", got_cnt - got0, 1);

        // Framing error followed by a long break: one pulse only.
        clkdiv = 32'd3;
        fe0 = fe_cnt; val0 = val_cycles; got0 = got_cnt;
        send(8'h00, 4, 1'b0);
        rx = 1'b0;
        tick(400);
        rx = 1'b1;
        tick(12);
        check("brk_ferr", fe_cnt - fe0, 1);
        check("brk_valid", val_cycles - val0, 0);
        exp_q.push_back(8'h81);
        send(8'h81, 4, 1'b1);
        tick(4);
        check("brk_next", got_cnt - got0, 1);

        // Overrun: second byte dropped while the first is held.
        bus.ready = 1'b0;
        ov0 = ov_cnt;
        exp_q.push_back(8'h11);
        send(8'h11, 4, 1'b1);
        send(8'h22, 4, 1'b1);
        tick(4);
        check("ovr_valid", {31'd0, bus.valid}, 32'd1);
        check("ovr_data", {24'd0, bus.data}, 32'h11);
        check("ovr_pulse", ov_cnt - ov0, 1);
        bus.ready = 1'b1;
        tick(1);
        bus.ready = 1'b0;
        tick(1);
        check("ovr_drain", {31'd0, bus.valid}, 32'd0);

        // Consume on exactly the stop-sample edge of the next byte.
        ov0 = ov_cnt;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hC3);
        send(8'h5A, 4, 1'b1);
        fork
            send(8'hC3, 4, 1'b1);
            begin
                repeat (3 + 1 + 36) @(posedge clk);
                #1;
                bus.ready = 1'b1;
                @(posedge clk);
                #1;
                bus.ready = 1'b0;
                check("sim_valid", {31'd0, bus.valid}, 32'd1);
                check("sim_data", {24'd0, bus.data}, 32'hC3);
                check("sim_ovr", ov_cnt - ov0, 0);
            end
        join
        bus.ready = 1'b1;
        tick(1);
        bus.ready = 1'b0;
        tick(2);

        // Randomized streams with random consumer stalls.
        for (int d = 0; d < 4; d++) begin
            clkdiv = divs[d];
            t = int'(divs[d]) + 1;
            nb = (d == 3) ? 3 : 256;
            fe0 = fe_cnt; ov0 = ov_cnt; got0 = got_cnt;
            done = 1'b0;
            stall = 0;
            fork
                begin
                    for (int i = 0; i < nb; i++) begin
                        logic [7:0] b;
                        b = (d == 3) ? 8'($urandom) : 8'(i);
                        tick($urandom_range(0, 3));
                        exp_q.push_back(b);
                        send(b, t, 1'b1);
                    end
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        bus.ready = ($urandom_range(0, 2) != 0) || (stall >= 3);
                        tick(1);
                        stall = (bus.valid && !bus.ready) ? stall + 1 : 0;
                    end
                end
            join
            bus.ready = 1'b1;
            h = 0;
            while (exp_q.size() != 0 && h < 64) begin
                tick(1);
                h++;
            end
            tick(2);
            check("rnd_drained", exp_q.size(), 0);
            check("rnd_count", got_cnt - got0, nb);
            check("rnd_ferr", fe_cnt - fe0, 0);
            check("rnd_ovr", ov_cnt - ov0, 0);
        end

        // Reset in the middle of a frame discards the partial byte.
        clkdiv = 32'd7;
        fe0 = fe_cnt; val0 = val_cycles;
        rx = 1'b0;
        tick(24);
        rst = 1'b1;
        rx = 1'b1;
        tick(2);
        check("mid_rst_valid", {31'd0, bus.valid}, 32'd0);
        check("mid_rst_data", {24'd0, bus.data}, 32'd0);
        rst = 1'b0;
        tick(120);
        check("mid_rst_novalid", val_cycles - val0, 0);
        check("mid_rst_ferr", fe_cnt - fe0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver that pairs with the team's UART transmitter: 8 data bits, LSB first, no parity, 1 stop bit, idle-high line. It synchronises the `rx` pin, validates the start bit at mid-bit, samples each data bit at mid-bit, and presents received bytes on a single-entry valid/ready output register. Bit timing uses the same `clkdiv` convention as the transmitter, so both ends driven with equal `clkdiv` interoperate.

## Interface
- No parameters.
- `clk`  input  1  clock.
- `rst`  input  1  reset, synchronous, active-high.
- `clkdiv`  input  32  bit period minus one, in `clk` cycles. Must be held stable while a frame is in progress.
- `rx`  input  1  serial line, asynchronous to `clk`.
- `valid`  output  1  `data` holds an unconsumed byte.
- `ready`  input  1  consumer accepts the byte in any cycle where `valid && ready`.
- `data`  output  8  received byte.
- `frame_err`  output  1  one-cycle pulse: the stop bit was sampled low.
- `overrun`  output  1  one-cycle pulse: a good byte was dropped because the output register was full.

## Operation
- **Bit period and half period:**
  - T = `clkdiv` + 1 cycles.
  - H = `clkdiv` >> 1, using logical shift on the 32-bit value.
- **Synchroniser:** two flip-flops, both reset to 1. `rx_s` is the second stage. The FSM only ever reads `rx_s`.
- **Registers:**
  - `clkcnt[31:0]`: counts down.
  - `bitcnt[3:0]`.
  - `shreg[7:0]`.
  - Output register: `data` and `valid`.
- **FSM states:** IDLE, START, DATA, STOP, BREAK.
- **IDLE:** when `rx_s == 0`, set `clkcnt <= H` and go to START.
- **START:** decrement `clkcnt`. When `clkcnt == 0`:
  - `rx_s == 0`: set `clkcnt <= clkdiv` and `bitcnt <= 0`, then go to DATA.
  - `rx_s == 1`: treat as a glitch and go to IDLE. No outputs change.
- **DATA:** decrement `clkcnt`. When `clkcnt == 0`:
  - `shreg <= {rx_s, shreg[7:1]}`.
  - `clkcnt <= clkdiv`.
  - `bitcnt <= bitcnt + 1`.
  - If `bitcnt == 7`, go to STOP.
- **STOP:** decrement `clkcnt`. When `clkcnt == 0`:
  - `rx_s == 1`: deliver the byte, then go to IDLE.
  - `rx_s == 0`: pulse `frame_err`, drop the byte, go to BREAK.
- **BREAK:** wait for `rx_s == 1`, then go to IDLE. A line held low (break) therefore produces exactly one `frame_err`, not repeated frames.
- **Deliver:**
  - If the output register is free, load `data <= shreg` and `valid <= 1`.
  - The output register is free when `valid == 0`, or when `valid && ready` in the same cycle.
  - Otherwise pulse `overrun`. `data` and `valid` stay unchanged and the new byte is lost.
- **Handshake:**
  - `valid && ready` clears `valid` next cycle, unless a delivery loads a new byte in that same cycle, in which case `valid` stays 1 and `data` updates.
  - `ready` while `valid == 0` has no effect.
  - `data` holds its value while `valid == 1`. `data` is also stable after consumption, until the next delivery.
- **Reset values:**
  - `valid` = 0.
  - `data` = 0x00.
  - `frame_err` = 0.
  - `overrun` = 0.
  - State = IDLE, `clkcnt` = 0, `bitcnt` = 0, `shreg` = 0.
  - Both synchroniser flops = 1.
- **Reset mid-frame:**
  - The partial byte is discarded and the FSM returns to IDLE.
  - After reset releases, a line still low is treated as a new start bit. This is acceptable; the receiver is expected to resync at the next framing boundary.
- **`clkdiv == 0`:** T = 1 and H = 0. Behaviour is functional, but there is only one sample per bit.

## Timing
- Let edge k be the first `clk` edge at which the first synchroniser flop captures `rx` low.
- `rx_s` is low after edge k+1. The FSM enters START at edge k+2.
- The start-bit sample is taken at edge k+3+H.
- Data bit i (i = 0..7) is sampled at edge k+3+H+(i+1)·T.
- The stop bit is sampled at edge k+3+H+9·T.
- `valid`, `frame_err` and `overrun` change at the stop-sample edge.
- The receiver is ready for the next start bit on the cycle after the stop sample. This tolerates back-to-back frames, including the transmitter's extra idle period.
- Throughput is one byte per frame. No bubbles are required from the consumer beyond the single-entry buffer.

## Test plan
- **Latency:** `clkdiv=3` (T=4, H=1), drive byte 0x A5 framed at 4 cycles/bit, `ready=1` → `valid` rises exactly 40 edges after edge k, `data=0xA5`, no error pulses.
- **Start glitch:** `clkdiv=15`, `rx` low for 3 cycles then high → no `valid`, no `frame_err`, FSM back in IDLE. A following 0x3C frame is received correctly.
- **Framing error and break:** 0x00 with stop bit low, then `rx` held low for 100 bit periods → exactly one `frame_err` pulse and no `valid`. After `rx` returns high, a 0x81 frame is received.
- **Overrun:** `ready=0`, send 0x11 then 0x22 back-to-back → `valid=1` with `data=0x11`, one `overrun` pulse at the second stop sample, `data` still 0x11.
- **Simultaneous consume and deliver:** hold the first byte and assert `ready` exactly on the second stop-sample edge → no `overrun`, `valid` stays 1, `data` = second byte.
- **Loopback:** connect `uart_tx.tx` to `rx` with `clkdiv=0`, 1, 7 and 434. Send 256 bytes 0x00..0xFF with random `ready` stalls kept within one frame → all bytes received in order, no errors. Assert `rst` mid-frame → no spurious `valid`.
